// File: rtl/program_loader.sv
// Boot-time loader: streams a program image into CPU memory from address 0,
// verifies a trailing 8-bit checksum, then releases the CPU from reset.
module program_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_resetn,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, FAIL} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sum_nxt;
  logic              len_ok;
  logic              xfer;

  assign len_ok  = (load_len != '0) && (load_len <= MAX_LEN);
  assign xfer    = in_valid && in_ready;
  assign sum_nxt = sum + in_data;

  // Outputs are registered next to the state so none depends combinationally
  // on an input; each transition sets the full output set of the target state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      len        <= '0;
      sum        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_resetn <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        IDLE, RUN, FAIL: begin
          if (start) begin
            cpu_resetn <= 1'b0;
            done       <= 1'b0;
            if (len_ok) begin
              state    <= LOAD;
              len      <= load_len;
              cnt      <= '0;
              sum      <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              err      <= 1'b0;
            end else begin
              state    <= FAIL;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt[ADDR_W-1:0];
            mem_wdata <= in_data;
            sum       <= sum_nxt;
            cnt       <= cnt + 1'b1;
            if (cnt == len - 1'b1) state <= CHECK;
          end
        end
        CHECK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (sum_nxt == '0) begin
              state      <= RUN;
              done       <= 1'b1;
              cpu_resetn <= 1'b1;
            end else begin
              state <= FAIL;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          cpu_resetn <= 1'b0;
          in_ready   <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          err        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a per-cycle vector table for the basic
// load/verify/fail/reload flow, plus hand-written multi-cycle sequences.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [6:0] load_len = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, mem_we, cpu_resetn, busy, done, err;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;

  program_loader #(.ADDR_W(6), .DATA_W(8), .DEPTH(64)) dut (
    .clk(clk), .resetn(resetn), .start(start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_resetn(cpu_resetn), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // flags = {cpu_resetn, in_ready, busy, done, err}
  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_LOAD = 5'b01100;
  localparam logic [4:0] F_RUN  = 5'b10010;
  localparam logic [4:0] F_FAIL = 5'b00001;

  typedef struct {
    logic       s;
    logic [6:0] len;
    logic       v;
    logic [7:0] d;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wd;
    logic [4:0] flags;
  } vec_t;

  vec_t vecs[$];
  int   npass = 0;
  int   ntot  = 0;
  int   we_cnt = 0;

  always @(negedge clk) if (mem_we) we_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_flags(input string nm, input logic [4:0] f);
    chk(nm, {27'd0, cpu_resetn, in_ready, busy, done, err}, {27'd0, f});
  endtask

  task automatic step(input logic s, input logic [6:0] l, input logic v, input logic [7:0] d);
    start = s; load_len = l; in_valid = v; in_data = d;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) resetn = 1'b0;
    @(negedge clk) resetn = 1'b1;
  endtask

  initial begin
    int base;
    string nm;

    // len=3 E0,21,22 + DD -> RUN; reload with bad DC -> FAIL; reload with DD -> RUN
    vecs.push_back('{1, 7'd3, 0, 8'h00, 0, 6'd0, 8'h00, F_LOAD});
    vecs.push_back('{0, 7'd0, 1, 8'hE0, 1, 6'd0, 8'hE0, F_LOAD});
    vecs.push_back('{0, 7'd0, 1, 8'h21, 1, 6'd1, 8'h21, F_LOAD});
    vecs.push_back('{0, 7'd0, 1, 8'h22, 1, 6'd2, 8'h22, F_LOAD});
    vecs.push_back('{0, 7'd0, 1, 8'hDD, 0, 6'd0, 8'h00, F_RUN});
    vecs.push_back('{0, 7'd0, 0, 8'h00, 0, 6'd0, 8'h00, F_RUN});
    vecs.push_back('{1, 7'd3, 0, 8'h00, 0, 6'd0, 8'h00, F_LOAD});
    vecs.push_back('{0, 7'd0, 1, 8'hE0, 1, 6'd0, 8'hE0, F_LOAD});
    vecs.push_back('{0, 7'd0, 1, 8'h21, 1, 6'd1, 8'h21, F_LOAD});
    vecs.push_back('{0, 7'd0, 1, 8'h22, 1, 6'd2, 8'h22, F_LOAD});
    vecs.push_back('{0, 7'd0, 1, 8'hDC, 0, 6'd0, 8'h00, F_FAIL});
    vecs.push_back('{0, 7'd0, 1, 8'h55, 0, 6'd0, 8'h00, F_FAIL});
    vecs.push_back('{1, 7'd3, 0, 8'h00, 0, 6'd0, 8'h00, F_LOAD});
    vecs.push_back('{0, 7'd0, 1, 8'hE0, 1, 6'd0, 8'hE0, F_LOAD});
    vecs.push_back('{1, 7'd0, 1, 8'h21, 1, 6'd1, 8'h21, F_LOAD});
    vecs.push_back('{0, 7'd0, 1, 8'h22, 1, 6'd2, 8'h22, F_LOAD});
    vecs.push_back('{0, 7'd0, 1, 8'hDD, 0, 6'd0, 8'h00, F_RUN});

    // reset values while resetn is low
    #12;
    chk_flags("reset_flags", F_IDLE);
    chk("reset_we", {31'd0, mem_we}, 32'd0);
    chk("reset_addr", {26'd0, mem_addr}, 32'd0);
    chk("reset_wdata", {24'd0, mem_wdata}, 32'd0);
    resetn = 1'b1;
    step(0, 0, 1, 8'h77);
    chk_flags("idle_ignores_valid", F_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].s, vecs[i].len, vecs[i].v, vecs[i].d);
      nm = $sformatf("vec%0d", i);
      chk_flags({nm, "_flags"}, vecs[i].flags);
      chk({nm, "_we"}, {31'd0, mem_we}, {31'd0, vecs[i].we});
      if (vecs[i].we) begin
        chk({nm, "_addr"}, {26'd0, mem_addr}, {26'd0, vecs[i].addr});
        chk({nm, "_wdata"}, {24'd0, mem_wdata}, {24'd0, vecs[i].wd});
      end
    end

    // full-depth image 0x00..0x3F, sum 0xE0, checksum 0x20
    base = we_cnt;
    step(1, 7'd64, 0, 8'h00);
    chk_flags("len64_start", F_LOAD);
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 1, 8'(i));
      chk("len64_we", {31'd0, mem_we}, 32'd1);
      chk("len64_addr", {26'd0, mem_addr}, i);
      chk("len64_wdata", {24'd0, mem_wdata}, i);
    end
    chk_flags("len64_in_check", F_LOAD);
    step(0, 0, 1, 8'h20);
    chk_flags("len64_run", F_RUN);
    chk("len64_no_rewrite", {31'd0, mem_we}, 32'd0);
    chk("len64_last_addr", {26'd0, mem_addr}, 32'd63);
    chk("len64_write_count", we_cnt - base, 32'd64);

    // illegal lengths
    do_reset();
    base = we_cnt;
    step(1, 7'd0, 1, 8'h11);
    chk_flags("len0_fail", F_FAIL);
    step(0, 0, 1, 8'h11);
    chk_flags("fail_holds", F_FAIL);
    step(1, 7'd65, 1, 8'h11);
    chk_flags("len65_fail", F_FAIL);
    chk("illegal_no_writes", we_cnt - base, 32'd0);

    // gapped valid: 1,0,0 pattern over 4 words, sum 0xA0, checksum 0x60
    base = we_cnt;
    step(1, 7'd4, 0, 8'h00);
    chk_flags("gap_start_clears_err", F_LOAD);
    for (int w = 0; w < 4; w++) begin
      step(0, 0, 1, 8'(8'h10 * (w + 1)));
      chk("gap_we", {31'd0, mem_we}, 32'd1);
      chk("gap_addr", {26'd0, mem_addr}, w);
      chk("gap_wdata", {24'd0, mem_wdata}, 32'h10 * (w + 1));
      step(0, 0, 0, 8'hFF);
      chk("gap_idle_we", {31'd0, mem_we}, 32'd0);
      step(0, 0, 0, 8'hFF);
    end
    step(0, 0, 1, 8'h60);
    chk_flags("gap_run", F_RUN);
    chk("gap_write_count", we_cnt - base, 32'd4);

    // async reset after 2 of 3 words
    step(1, 7'd3, 0, 8'h00);
    step(0, 0, 1, 8'hE0);
    step(0, 0, 1, 8'h21);
    chk("mid_we_before_reset", {31'd0, mem_we}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk_flags("mid_reset_flags", F_IDLE);
    chk("mid_reset_we", {31'd0, mem_we}, 32'd0);
    chk("mid_reset_addr", {26'd0, mem_addr}, 32'd0);
    chk("mid_reset_wdata", {24'd0, mem_wdata}, 32'd0);
    @(negedge clk) resetn = 1'b1;
    step(0, 0, 1, 8'h22);
    chk_flags("post_reset_idle", F_IDLE);

    // start from RUN: cpu_resetn falls on the start edge
    step(1, 7'd1, 0, 8'h00);
    step(0, 0, 1, 8'h05);
    step(0, 0, 1, 8'hFB);
    chk_flags("len1_run", F_RUN);
    @(negedge clk);
    start = 1'b1; load_len = 7'd2;
    #1;
    chk("run_crn_before_edge", {31'd0, cpu_resetn}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("run_crn_after_start", {31'd0, cpu_resetn}, 32'd0);
    chk_flags("run_restart_flags", F_LOAD);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
